// File: rtl/calc_pkg.sv
// calc_pkg: constants and types shared by the keypad decoder, the calculator
// sequencing FSM and the ALU.
//   OP_*     : 2-bit operator codes carried on op_val
//   KEY_*    : 4-bit internal key codes (0-9 digits, A-D operators, EQ, CLR)
//   kp_state_e : keypad scan FSM states
//   key_code() : (row, col) -> key code lookup for the 4x4 keypad
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] KEY_A   = 4'hA;
  localparam logic [3:0] KEY_B   = 4'hB;
  localparam logic [3:0] KEY_C   = 4'hC;
  localparam logic [3:0] KEY_D   = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    KP_SCAN,
    KP_DEB_PRESS,
    KP_EMIT,
    KP_HELD
  } kp_state_e;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'h0: k = 4'd1;
      4'h1: k = 4'd2;
      4'h2: k = 4'd3;
      4'h3: k = KEY_A;
      4'h4: k = 4'd4;
      4'h5: k = 4'd5;
      4'h6: k = 4'd6;
      4'h7: k = KEY_B;
      4'h8: k = 4'd7;
      4'h9: k = 4'd8;
      4'hA: k = 4'd9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_CLR;
      4'hD: k = 4'd0;
      4'hE: k = KEY_EQ;
      default: k = KEY_D;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running prescaler for the keypad scanner.
//   clk, rst : clock, synchronous active-high reset
//   tick     : 1-cycle pulse every SCAN_DIV clocks (counter 0..SCAN_DIV-1)
module keypad_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(SCAN_DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: 4x4 matrix keypad scanner / debouncer producing one
// single-cycle event per accepted key press.
//   clk, rst  : clock, synchronous active-high reset
//   row_in    : keypad rows, active-low, asynchronous
//   col_out   : column drive, active-low, one-cold
//   is_num/is_op/is_eq/is_clr : mutually exclusive 1-cycle strobes
//   num_val   : digit 0-9 (valid with is_num, held otherwise)
//   op_val    : operator code (valid with is_op, held otherwise)
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (digit auto-repeat while held).
module keypad_decoder
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       is_num,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic [3:0] num_val,
  output logic [1:0] op_val
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]    row_m, row_s;
  logic          tick;
  kp_state_e     state, state_n;
  logic [1:0]    col_idx, col_n;
  logic [3:0]    lat_row, lat_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          is_num_n, is_op_n, is_eq_n, is_clr_n;
  logic [3:0]    num_n;
  logic [1:0]    op_n;
  logic [1:0]    row_idx;
  logic          one_key;
  logic [3:0]    code;
  logic          cnt_last;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  assign col_out = ~(4'b0001 << col_idx);

  // Decode works on the latched row pattern and the frozen column, so it is
  // stable through debounce, emit and hold.
  always_comb begin
    row_idx = 2'd0;
    case (lat_row)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  assign one_key  = $onehot(~lat_row);
  assign code     = key_code(row_idx, col_idx);
  assign cnt_last = (cnt == CW'(DEBOUNCE_CNT - 1));

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_cnt, rep_n;

  always_ff @(posedge clk) begin
    if (rst) rep_cnt <= '0;
    else     rep_cnt <= rep_n;
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_TICKS;
`endif

  always_comb begin
    state_n  = state;
    col_n    = col_idx;
    lat_n    = lat_row;
    cnt_n    = cnt;
    is_num_n = 1'b0;
    is_op_n  = 1'b0;
    is_eq_n  = 1'b0;
    is_clr_n = 1'b0;
    num_n    = num_val;
    op_n     = op_val;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n    = rep_cnt;
`endif
    case (state)
      KP_SCAN: if (tick) begin
        if (row_s == 4'hF) begin
          col_n = col_idx + 2'd1;
        end else begin
          lat_n   = row_s;
          cnt_n   = '0;
          state_n = KP_DEB_PRESS;
        end
      end
      KP_DEB_PRESS: if (tick) begin
        if (row_s != lat_row) begin
          state_n = KP_SCAN;
        end else if (cnt_last) begin
          state_n = KP_EMIT;
          // Strobes are registered, so they are high during the EMIT cycle;
          // multi-row presses fall through with no strobe.
          if (one_key) begin
            case (code)
              KEY_A:   begin is_op_n = 1'b1; op_n = OP_ADD; end
              KEY_B:   begin is_op_n = 1'b1; op_n = OP_SUB; end
              KEY_C:   begin is_op_n = 1'b1; op_n = OP_MUL; end
              KEY_D:   begin is_op_n = 1'b1; op_n = OP_DIV; end
              KEY_EQ:  is_eq_n  = 1'b1;
              KEY_CLR: is_clr_n = 1'b1;
              default: begin is_num_n = 1'b1; num_n = code; end
            endcase
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      KP_EMIT: begin
        state_n = KP_HELD;
        cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n   = '0;
`endif
      end
      default: if (tick) begin
        // HELD: wait for DEBOUNCE_CNT consecutive clean ticks.
        if (row_s == 4'hF) begin
          if (cnt_last) state_n = KP_SCAN;
          else          cnt_n   = cnt + 1'b1;
        end else begin
          cnt_n = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (row_s == lat_row && one_key && code <= 4'd9) begin
          if (rep_cnt == RW'(REPEAT_TICKS - 1)) begin
            is_num_n = 1'b1;
            num_n    = code;
            rep_n    = '0;
          end else begin
            rep_n = rep_cnt + 1'b1;
          end
        end else begin
          rep_n = '0;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= KP_SCAN;
      col_idx <= 2'd0;
      lat_row <= 4'hF;
      cnt     <= '0;
      is_num  <= 1'b0;
      is_op   <= 1'b0;
      is_eq   <= 1'b0;
      is_clr  <= 1'b0;
      num_val <= 4'd0;
      op_val  <= 2'd0;
    end else begin
      state   <= state_n;
      col_idx <= col_n;
      lat_row <= lat_n;
      cnt     <= cnt_n;
      is_num  <= is_num_n;
      is_op   <= is_op_n;
      is_eq   <= is_eq_n;
      is_clr  <= is_clr_n;
      num_val <= num_n;
      op_val  <= op_n;
    end
  end

endmodule
